mips_multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath: one shared memory port and one ALU, reused across FETCH/DECODE/EXEC/MEM/WB states.
- Decodes OPCODE/FUNCT from the instruction register, drives per-state datapath strobes, and waits on a memory ready handshake.
- Supports the same instruction set as the single-cycle core: add, sub, and, or, slt, addi, lw, sw, beq, j.
- Sits between the instruction register and the PC, register file, ALU and memory muxes.

---
 rtl/mips_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared memory port and ALU.
// Define MIPS_MC_PERF_CNT_EN to add the CYCLE_CNT/INSTR_CNT performance counter outputs.
module mips_multicycle_ctrl #(
    parameter int ILLEGAL_HALT = 1
`ifdef MIPS_MC_PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RUN,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ZERO,
    input  logic       MEM_READY,
    output logic       PC_WRITE,
    output logic       IR_WRITE,
    output logic       IORD,
    output logic       MEM_READ,
    output logic       MEM_WRITE,
    output logic       REG_DST,
    output logic       REG_WRITE,
    output logic       MEM2REG,
    output logic       EX_TOP,
    output logic       ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [3:0] ALU_OP,
    output logic [1:0] PC_SRC,
    output logic       HALTED,
`ifdef MIPS_MC_PERF_CNT_EN
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic [CNT_W-1:0] INSTR_CNT,
`endif
    output logic       INSTR_DONE
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t     state_q, state_d;
    state_t     done_next;
    logic       r_legal;
    logic [3:0] r_alu_op;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        r_legal  = 1'b1;
        r_alu_op = ALU_ADD;
        case (FUNCT)
            6'b100000: r_alu_op = ALU_ADD;
            6'b100010: r_alu_op = ALU_SUB;
            6'b100100: r_alu_op = ALU_AND;
            6'b100101: r_alu_op = ALU_OR;
            6'b101010: r_alu_op = ALU_SLT;
            default:   r_legal  = 1'b0;
        endcase
    end

    // NOTE: every output and state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        done_next  = RUN ? S_FETCH : S_IDLE;
        PC_WRITE   = 1'b0;
        IR_WRITE   = 1'b0;
        IORD       = 1'b0;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        REG_DST    = 1'b0;
        REG_WRITE  = 1'b0;
        MEM2REG    = 1'b0;
        EX_TOP     = 1'b0;
        ALU_SRC_A  = 1'b0;
        ALU_SRC_B  = 2'b00;
        ALU_OP     = 4'b0000;
        PC_SRC     = 2'b00;
        HALTED     = 1'b0;
        INSTR_DONE = 1'b0;
        case (state_q)
            S_IDLE: if (RUN) state_d = S_FETCH;
            S_FETCH: begin
                MEM_READ  = 1'b1;
                ALU_SRC_B = 2'b01;
                ALU_OP    = ALU_ADD;
                if (MEM_READY) begin
                    IR_WRITE = 1'b1;
                    PC_WRITE = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALU_SRC_B = 2'b11;
                ALU_OP    = ALU_ADD;
                EX_TOP    = 1'b1;
                case (OPCODE)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = r_legal ? S_R_EXEC : S_HALT;
                    OP_ADDI:      state_d = S_I_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
                // Illegal encodings retire as a NOP when halting is disabled.
                if (state_d == S_HALT && ILLEGAL_HALT == 0) begin
                    INSTR_DONE = 1'b1;
                    state_d    = done_next;
                end
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = 2'b10;
                EX_TOP    = 1'b1;
                ALU_OP    = ALU_ADD;
                if (state_q == S_I_EXEC) state_d = S_I_WB;
                else                     state_d = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MEM_READ = 1'b1;
                IORD     = 1'b1;
                if (MEM_READY) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                REG_WRITE  = 1'b1;
                MEM2REG    = 1'b1;
                INSTR_DONE = 1'b1;
                state_d    = done_next;
            end
            S_MEM_WR: begin
                MEM_WRITE = 1'b1;
                IORD      = 1'b1;
                if (MEM_READY) begin
                    INSTR_DONE = 1'b1;
                    state_d    = done_next;
                end
            end
            S_R_EXEC: begin
                ALU_SRC_A = 1'b1;
                ALU_OP    = r_alu_op;
                state_d   = S_R_WB;
            end
            S_R_WB, S_I_WB: begin
                REG_WRITE  = 1'b1;
                REG_DST    = (state_q == S_R_WB);
                INSTR_DONE = 1'b1;
                state_d    = done_next;
            end
            S_BRANCH: begin
                ALU_SRC_A  = 1'b1;
                ALU_OP     = ALU_SUB;
                PC_SRC     = 2'b01;
                PC_WRITE   = ZERO;
                INSTR_DONE = 1'b1;
                state_d    = done_next;
            end
            S_JUMP: begin
                PC_SRC     = 2'b10;
                PC_WRITE   = 1'b1;
                INSTR_DONE = 1'b1;
                state_d    = done_next;
            end
            S_HALT:  HALTED  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MIPS_MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            instr_cnt_q <= instr_cnt_q + CNT_W'(INSTR_DONE);
        end
    end

    assign CYCLE_CNT = cycle_cnt_q;
    assign INSTR_CNT = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle strobe vectors against hand-computed tables.
// A second instance with ILLEGAL_HALT=0 covers the NOP handling of illegal encodings.
module tb_mips_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N, RUN, ZERO, MEM_READY;
    logic [5:0] OPCODE, FUNCT;

    logic       PC_WRITE, IR_WRITE, IORD, MEM_READ, MEM_WRITE, REG_DST, REG_WRITE, MEM2REG;
    logic       EX_TOP, ALU_SRC_A, HALTED, INSTR_DONE;
    logic [1:0] ALU_SRC_B, PC_SRC;
    logic [3:0] ALU_OP;

    logic       n_pc_write, n_ir_write, n_iord, n_mem_read, n_mem_write, n_reg_dst, n_reg_write;
    logic       n_mem2reg, n_ex_top, n_alu_src_a, n_halted, n_instr_done;
    logic [1:0] n_alu_src_b, n_pc_src;
    logic [3:0] n_alu_op;

`ifdef MIPS_MC_PERF_CNT_EN
    logic [31:0] CYCLE_CNT, INSTR_CNT, n_cycle_cnt, n_instr_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 CLK = ~CLK;

    mips_multicycle_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
        .MEM_READY(MEM_READY), .PC_WRITE(PC_WRITE), .IR_WRITE(IR_WRITE), .IORD(IORD),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .REG_DST(REG_DST), .REG_WRITE(REG_WRITE),
        .MEM2REG(MEM2REG), .EX_TOP(EX_TOP), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
        .ALU_OP(ALU_OP), .PC_SRC(PC_SRC), .HALTED(HALTED),
`ifdef MIPS_MC_PERF_CNT_EN
        .CYCLE_CNT(CYCLE_CNT), .INSTR_CNT(INSTR_CNT),
`endif
        .INSTR_DONE(INSTR_DONE)
    );

    mips_multicycle_ctrl #(.ILLEGAL_HALT(0)) dut_nop (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
        .MEM_READY(MEM_READY), .PC_WRITE(n_pc_write), .IR_WRITE(n_ir_write), .IORD(n_iord),
        .MEM_READ(n_mem_read), .MEM_WRITE(n_mem_write), .REG_DST(n_reg_dst),
        .REG_WRITE(n_reg_write), .MEM2REG(n_mem2reg), .EX_TOP(n_ex_top),
        .ALU_SRC_A(n_alu_src_a), .ALU_SRC_B(n_alu_src_b), .ALU_OP(n_alu_op), .PC_SRC(n_pc_src),
        .HALTED(n_halted),
`ifdef MIPS_MC_PERF_CNT_EN
        .CYCLE_CNT(n_cycle_cnt), .INSTR_CNT(n_instr_cnt),
`endif
        .INSTR_DONE(n_instr_done)
    );

    // Field order: {PC_WRITE,IR_WRITE,IORD,MEM_READ,MEM_WRITE,REG_DST,REG_WRITE,MEM2REG},
    // {EX_TOP,ALU_SRC_A}, ALU_SRC_B, ALU_OP, PC_SRC, {HALTED,INSTR_DONE}.
    logic [19:0] outs, outs_nop;
    assign outs = {PC_WRITE, IR_WRITE, IORD, MEM_READ, MEM_WRITE, REG_DST, REG_WRITE, MEM2REG,
                   EX_TOP, ALU_SRC_A, ALU_SRC_B, ALU_OP, PC_SRC, HALTED, INSTR_DONE};
    assign outs_nop = {n_pc_write, n_ir_write, n_iord, n_mem_read, n_mem_write, n_reg_dst,
                       n_reg_write, n_mem2reg, n_ex_top, n_alu_src_a, n_alu_src_b, n_alu_op,
                       n_pc_src, n_halted, n_instr_done};

    localparam logic [19:0] V_IDLE     = '0;
    localparam logic [19:0] V_FETCH_W  = {8'b0001_0000, 2'b00, 2'b01, 4'b0010, 2'b00, 2'b00};
    localparam logic [19:0] V_FETCH_R  = {8'b1101_0000, 2'b00, 2'b01, 4'b0010, 2'b00, 2'b00};
    localparam logic [19:0] V_DECODE   = {8'b0000_0000, 2'b10, 2'b11, 4'b0010, 2'b00, 2'b00};
    localparam logic [19:0] V_DECODE_D = {8'b0000_0000, 2'b10, 2'b11, 4'b0010, 2'b00, 2'b01};
    localparam logic [19:0] V_ADDR     = {8'b0000_0000, 2'b11, 2'b10, 4'b0010, 2'b00, 2'b00};
    localparam logic [19:0] V_MEM_RD   = {8'b0011_0000, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00};
    localparam logic [19:0] V_MEM_WB   = {8'b0000_0011, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b01};
    localparam logic [19:0] V_MEM_WR_W = {8'b0010_1000, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00};
    localparam logic [19:0] V_MEM_WR_R = {8'b0010_1000, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b01};
    localparam logic [19:0] V_R_ADD    = {8'b0000_0000, 2'b01, 2'b00, 4'b0010, 2'b00, 2'b00};
    localparam logic [19:0] V_R_SLT    = {8'b0000_0000, 2'b01, 2'b00, 4'b0111, 2'b00, 2'b00};
    localparam logic [19:0] V_R_WB     = {8'b0000_0110, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b01};
    localparam logic [19:0] V_I_WB     = {8'b0000_0010, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b01};
    localparam logic [19:0] V_BEQ_Z1   = {8'b1000_0000, 2'b01, 2'b00, 4'b0110, 2'b01, 2'b01};
    localparam logic [19:0] V_BEQ_Z0   = {8'b0000_0000, 2'b01, 2'b00, 4'b0110, 2'b01, 2'b01};
    localparam logic [19:0] V_JUMP     = {8'b1000_0000, 2'b00, 2'b00, 4'b0000, 2'b10, 2'b01};
    localparam logic [19:0] V_HALT     = {8'b0000_0000, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b10};

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010;

    typedef struct packed {
        logic        run;
        logic        rdy;
        logic        zero;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [19:0] exp;
    } row_t;

    function automatic row_t mk(input logic run, input logic rdy, input logic zero,
                                input logic [5:0] op, input logic [5:0] fn, input logic [19:0] exp);
        mk = '{run: run, rdy: rdy, zero: zero, op: op, fn: fn, exp: exp};
    endfunction

    task automatic apply(input row_t r);
        RUN = r.run; MEM_READY = r.rdy; ZERO = r.zero; OPCODE = r.op; FUNCT = r.fn;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; RUN = 1'b0; MEM_READY = 1'b0; ZERO = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; RUN = 1'b1; MEM_READY = 1'b1; ZERO = 1'b1; OPCODE = OP_J; FUNCT = '0;
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vec_cnt++;
            if (outs !== V_IDLE) begin
                err_cnt++; $display("FAIL reset_hold[%0d]: got %b expected %b", i, outs, V_IDLE);
            end
            @(posedge CLK); #1;
        end
        RST_N = 1'b1; RUN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            vec_cnt++;
            if (outs !== V_IDLE) begin
                err_cnt++; $display("FAIL idle_norun[%0d]: got %b expected %b", i, outs, V_IDLE);
            end
            @(posedge CLK); #1;
        end
`ifdef MIPS_MC_PERF_CNT_EN
        vec_cnt++;
        if (CYCLE_CNT !== 32'd0 || INSTR_CNT !== 32'd0) begin
            err_cnt++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", CYCLE_CNT, INSTR_CNT);
        end
`endif
    endtask

    task automatic test_add();
        row_t seq[$];
        seq.push_back(mk(1, 1, 0, OP_R, 6'b100000, V_IDLE));
        seq.push_back(mk(1, 1, 0, OP_R, 6'b100000, V_FETCH_R));
        seq.push_back(mk(0, 1, 0, OP_R, 6'b100000, V_DECODE));
        seq.push_back(mk(0, 1, 0, OP_R, 6'b100000, V_R_ADD));
        seq.push_back(mk(0, 1, 0, OP_R, 6'b100000, V_R_WB));
        seq.push_back(mk(0, 1, 0, OP_R, 6'b100000, V_IDLE));
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge CLK);
            vec_cnt++;
            if (outs !== seq[i].exp) begin
                err_cnt++; $display("FAIL add[%0d]: got %b expected %b", i, outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_lw_waits();
        row_t seq[$];
        seq.push_back(mk(1, 0, 0, OP_LW, 6'd0, V_IDLE));
        seq.push_back(mk(0, 0, 0, OP_LW, 6'd0, V_FETCH_W));
        seq.push_back(mk(0, 0, 0, OP_LW, 6'd0, V_FETCH_W));
        seq.push_back(mk(0, 1, 0, OP_LW, 6'd0, V_FETCH_R));
        seq.push_back(mk(0, 1, 0, OP_LW, 6'd0, V_DECODE));
        seq.push_back(mk(0, 1, 0, OP_LW, 6'd0, V_ADDR));
        seq.push_back(mk(0, 0, 0, OP_LW, 6'd0, V_MEM_RD));
        seq.push_back(mk(0, 0, 0, OP_LW, 6'd0, V_MEM_RD));
        seq.push_back(mk(0, 0, 0, OP_LW, 6'd0, V_MEM_RD));
        seq.push_back(mk(0, 1, 0, OP_LW, 6'd0, V_MEM_RD));
        seq.push_back(mk(0, 1, 0, OP_LW, 6'd0, V_MEM_WB));
        seq.push_back(mk(0, 1, 0, OP_LW, 6'd0, V_IDLE));
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge CLK);
            vec_cnt++;
            if (outs !== seq[i].exp) begin
                err_cnt++; $display("FAIL lw_wait[%0d]: got %b expected %b", i, outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch();
        row_t seq[$];
        for (int z = 1; z >= 0; z--) begin
            seq.push_back(mk(1, 1, 1'(1 - z), OP_BEQ, 6'd0, V_IDLE));
            seq.push_back(mk(1, 1, 1'(1 - z), OP_BEQ, 6'd0, V_FETCH_R));
            seq.push_back(mk(0, 1, 1'(1 - z), OP_BEQ, 6'd0, V_DECODE));
            seq.push_back(mk(0, 1, 1'(z), OP_BEQ, 6'd0, (z == 1) ? V_BEQ_Z1 : V_BEQ_Z0));
            seq.push_back(mk(0, 1, 1'(z), OP_BEQ, 6'd0, V_IDLE));
        end
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge CLK);
            vec_cnt++;
            if (outs !== seq[i].exp) begin
                err_cnt++; $display("FAIL beq[%0d]: got %b expected %b", i, outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_illegal();
        logic [19:0] exp_h, exp_n;
        RUN = 1'b1; MEM_READY = 1'b1; ZERO = 1'b0; OPCODE = 6'b111111; FUNCT = 6'b100000;
        for (int i = 0; i < 23; i++) begin
            MEM_READY = 1'(i % 2);
            if (i < 3) MEM_READY = 1'b1;
            exp_h = (i == 0) ? V_IDLE : (i == 1) ? V_FETCH_R : (i == 2) ? V_DECODE : V_HALT;
            exp_n = (i == 0) ? V_IDLE : (i == 2 || i == 4) ? V_DECODE_D : V_FETCH_R;
            if (i == 3) MEM_READY = 1'b1;
            @(negedge CLK);
            vec_cnt++;
            if (outs !== exp_h) begin
                err_cnt++; $display("FAIL illegal_halt[%0d]: got %b expected %b", i, outs, exp_h);
            end
            if (i < 5) begin
                vec_cnt++;
                if (outs_nop !== exp_n) begin
                    err_cnt++; $display("FAIL illegal_nop[%0d]: got %b expected %b", i, outs_nop, exp_n);
                end
            end
            @(posedge CLK); #1;
        end
        do_reset();
        RUN = 1'b1; MEM_READY = 1'b1; OPCODE = OP_R; FUNCT = 6'b000001;
        for (int i = 0; i < 5; i++) begin
            exp_h = (i == 0) ? V_IDLE : (i == 1) ? V_FETCH_R : (i == 2) ? V_DECODE : V_HALT;
            @(negedge CLK);
            vec_cnt++;
            if (outs !== exp_h) begin
                err_cnt++; $display("FAIL bad_funct[%0d]: got %b expected %b", i, outs, exp_h);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid_wr();
        row_t seq[$];
        do_reset();
        seq.push_back(mk(1, 1, 0, OP_SW, 6'd0, V_IDLE));
        seq.push_back(mk(1, 1, 0, OP_SW, 6'd0, V_FETCH_R));
        seq.push_back(mk(0, 1, 0, OP_SW, 6'd0, V_DECODE));
        seq.push_back(mk(0, 0, 0, OP_SW, 6'd0, V_ADDR));
        seq.push_back(mk(0, 0, 0, OP_SW, 6'd0, V_MEM_WR_W));
        seq.push_back(mk(0, 0, 0, OP_SW, 6'd0, V_MEM_WR_W));
        foreach (seq[i]) begin
            apply(seq[i]);
            if (i == 5) RST_N = 1'b0;
            @(negedge CLK);
            vec_cnt++;
            if (outs !== seq[i].exp) begin
                err_cnt++; $display("FAIL sw_reset[%0d]: got %b expected %b", i, outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
        RST_N = 1'b1; RUN = 1'b0; MEM_READY = 1'b1;
        @(negedge CLK);
        vec_cnt++;
        if (outs !== V_IDLE) begin
            err_cnt++; $display("FAIL sw_reset_idle: got %b expected %b", outs, V_IDLE);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        row_t seq[$];
        do_reset();
        seq.push_back(mk(1, 1, 0, OP_SW, 6'd0, V_IDLE));
        seq.push_back(mk(1, 1, 0, OP_SW, 6'd0, V_FETCH_R));
        seq.push_back(mk(1, 1, 0, OP_SW, 6'd0, V_DECODE));
        seq.push_back(mk(1, 1, 0, OP_SW, 6'd0, V_ADDR));
        seq.push_back(mk(1, 1, 0, OP_SW, 6'd0, V_MEM_WR_R));
        seq.push_back(mk(1, 1, 0, OP_J, 6'd0, V_FETCH_R));
        seq.push_back(mk(1, 1, 0, OP_J, 6'd0, V_DECODE));
        seq.push_back(mk(1, 1, 0, OP_J, 6'd0, V_JUMP));
        seq.push_back(mk(1, 1, 0, OP_ADDI, 6'd0, V_FETCH_R));
        seq.push_back(mk(0, 1, 0, OP_ADDI, 6'd0, V_DECODE));
        seq.push_back(mk(0, 1, 0, OP_ADDI, 6'd0, V_ADDR));
        seq.push_back(mk(0, 1, 0, OP_ADDI, 6'd0, V_I_WB));
        seq.push_back(mk(1, 1, 0, OP_R, 6'b101010, V_IDLE));
        seq.push_back(mk(1, 1, 0, OP_R, 6'b101010, V_FETCH_R));
        seq.push_back(mk(0, 1, 0, OP_R, 6'b101010, V_DECODE));
        seq.push_back(mk(0, 1, 0, OP_R, 6'b101010, V_R_SLT));
        seq.push_back(mk(0, 1, 0, OP_R, 6'b101010, V_R_WB));
        seq.push_back(mk(0, 1, 0, OP_R, 6'b101010, V_IDLE));
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge CLK);
            vec_cnt++;
            if (outs !== seq[i].exp) begin
                err_cnt++; $display("FAIL b2b[%0d]: got %b expected %b", i, outs, seq[i].exp);
            end
`ifdef MIPS_MC_PERF_CNT_EN
            if (i == 12) begin
                vec_cnt++;
                if (INSTR_CNT !== 32'd3 || CYCLE_CNT !== 32'd11) begin
                    err_cnt++;
                    $display("FAIL perf_cnt: got instr=%0d cycle=%0d expected instr=3 cycle=11",
                             INSTR_CNT, CYCLE_CNT);
                end
            end
`endif
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_waits();
        test_branch();
        test_illegal();
        test_reset_mid_wr();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
